// File: rtl/sync_input_debouncer.sv
// Per-bit contact debouncer for already-synchronised discrete inputs: a shared
// tick prescaler, per-bit qualification counters, edge pulses and sticky change flags.

module sync_input_debouncer_lane #(
  parameter int   DEBOUNCE_TICKS = 5,
  parameter logic RST_VAL        = 1'b1
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic tick_i,
  input  logic din_i,
  input  logic clr_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o,
  output logic chg_o
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          chg_q, chg_d;
  logic          flip;

  // Any agreeing sample restarts qualification; only ticks advance it.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    flip  = 1'b0;
    if (din_i == lvl_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        flip  = 1'b1;
        lvl_d = din_i;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = flip & din_i;
    fall_d = flip & ~din_i;
    chg_d  = flip | (chg_q & ~clr_i);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q  <= '0;
      lvl_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
    end
  end

  assign dout_o = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign chg_o  = chg_q;

endmodule

module sync_input_debouncer #(
  parameter int                    DATA_WIDTH     = 4,
  parameter int                    TICK_DIV       = 122880,
  parameter int                    DEBOUNCE_TICKS = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = {DATA_WIDTH{1'b1}}
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [DATA_WIDTH-1:0] rise,
  output logic [DATA_WIDTH-1:0] fall,
  output logic [DATA_WIDTH-1:0] changed,
  input  logic [DATA_WIDTH-1:0] clear_changed,
  output logic                  tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] ps_q, ps_d;
  logic          tick_q, tick_d;

  // tick is registered, so it is visible the cycle after the counter wraps.
  always_comb begin
    tick_d = (ps_q == PS_LAST);
    ps_d   = tick_d ? '0 : ps_q + PW'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_lane
    sync_input_debouncer_lane #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .RST_VAL       (RESET_VALUE[g])
    ) u_lane (
      .aclk   (aclk),
      .aresetn(aresetn),
      .tick_i (tick_q),
      .din_i  (din[g]),
      .clr_i  (clear_changed[g]),
      .dout_o (dout[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g]),
      .chg_o  (changed[g])
    );
  end

endmodule

// File: tb/tb_sync_input_debouncer.sv
// Directed bench for sync_input_debouncer: a vector table for the main flows plus
// hand-written bounce, reset and TICK_DIV=1 sequences.

module tb_sync_input_debouncer;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [3:0] din, dout, rise, fall, changed, clear_changed;
  logic       tick;
  logic [1:0] din1, dout1, rise1, fall1, changed1;
  logic       tick1;

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;
  bit mon_en  = 0;
  int rise_cnt[4];
  int fall_cnt[4];

  always #5 aclk = ~aclk;

  sync_input_debouncer #(
    .DATA_WIDTH(4), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .RESET_VALUE(4'hF)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .din(din), .dout(dout), .rise(rise), .fall(fall),
    .changed(changed), .clear_changed(clear_changed), .tick(tick)
  );

  sync_input_debouncer #(
    .DATA_WIDTH(2), .TICK_DIV(1), .DEBOUNCE_TICKS(1), .RESET_VALUE(2'b01)
  ) dut1 (
    .aclk(aclk), .aresetn(aresetn), .din(din1), .dout(dout1), .rise(rise1), .fall(fall1),
    .changed(changed1), .clear_changed(2'b00), .tick(tick1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Edges since reset release, used to predict the prescaler tick.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  always @(negedge aclk) begin
    if (mon_en) begin
      chk("tick",  {31'd0, tick},  {31'd0, (ecnt != 0) && (ecnt % 4 == 0)});
      chk("tick1", {31'd0, tick1}, {31'd0, ecnt >= 1});
      chk("rf_excl",  {28'd0, rise & fall},   32'd0);
      chk("rf_excl1", {30'd0, rise1 & fall1}, 32'd0);
      for (int i = 0; i < 4; i++) begin
        rise_cnt[i] = rise_cnt[i] + int'(rise[i]);
        fall_cnt[i] = fall_cnt[i] + int'(fall[i]);
      end
    end
  end

  typedef struct {
    logic [3:0] din;
    logic [3:0] clr;
    int         cyc;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] chg;
  } vec_t;

  vec_t vt[16];
  int   nv;

  task automatic apply(input int i);
    din           = vt[i].din;
    clear_changed = vt[i].clr;
    repeat (vt[i].cyc) step();
    chk($sformatf("vec%0d_dout", i), {28'd0, dout},    {28'd0, vt[i].dout});
    chk($sformatf("vec%0d_rise", i), {28'd0, rise},    {28'd0, vt[i].rise});
    chk($sformatf("vec%0d_fall", i), {28'd0, fall},    {28'd0, vt[i].fall});
    chk($sformatf("vec%0d_chg",  i), {28'd0, changed}, {28'd0, vt[i].chg});
  endtask

  int r0, f0;

  initial begin
    // Ticks become visible on cycles 4k after release and are consumed on edge 4k+1.
    nv = 0;
    // din[0] falls on cycle 41: tick edges 45, 49, 53
    vt[nv++] = '{4'hE, 4'h0, 11, 4'hF, 4'h0, 4'h0, 4'h0};
    vt[nv++] = '{4'hE, 4'h0,  1, 4'hE, 4'h0, 4'h1, 4'h1};
    vt[nv++] = '{4'hE, 4'h0,  1, 4'hE, 4'h0, 4'h0, 4'h1};
    // glitch on din[1] spans tick edges 57, 61 only; second low spans 69, 73, 77
    vt[nv++] = '{4'hC, 4'h0,  7, 4'hE, 4'h0, 4'h0, 4'h1};
    vt[nv++] = '{4'hE, 4'h0,  5, 4'hE, 4'h0, 4'h0, 4'h1};
    vt[nv++] = '{4'hC, 4'h0, 10, 4'hE, 4'h0, 4'h0, 4'h1};
    vt[nv++] = '{4'hC, 4'h0,  1, 4'hC, 4'h0, 4'h2, 4'h3};
    vt[nv++] = '{4'hC, 4'h0,  1, 4'hC, 4'h0, 4'h0, 4'h3};
    // sticky clear, then clear colliding with rise[0] on edge 129
    vt[nv++] = '{4'h9, 4'h1,  1, 4'h8, 4'h0, 4'h0, 4'h6};
    vt[nv++] = '{4'h9, 4'h0,  9, 4'h8, 4'h0, 4'h0, 4'h6};
    vt[nv++] = '{4'h9, 4'h1,  1, 4'h9, 4'h1, 4'h0, 4'h7};
    vt[nv++] = '{4'h9, 4'h0,  1, 4'h9, 4'h0, 4'h0, 4'h7};
    vt[nv++] = '{4'h9, 4'h1,  1, 4'h9, 4'h0, 4'h0, 4'h6};
    vt[nv++] = '{4'h9, 4'h0,  1, 4'h9, 4'h0, 4'h0, 4'h6};

    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    aresetn = 1'b1;
    din = 4'hF; din1 = 2'b01; clear_changed = 4'h0;
    #2 aresetn = 1'b0;
    #1 mon_en = 1;
    chk("rst_dout", {28'd0, dout},    32'hF);
    chk("rst_chg",  {28'd0, changed}, 32'h0);
    chk("rst_dout1", {30'd0, dout1},  32'h1);
    repeat (3) step();
    aresetn = 1'b1;

    // Quiet inputs for 40 cycles; dut1 exercises TICK_DIV=1, DEBOUNCE_TICKS=1.
    for (int c = 1; c <= 40; c++) begin
      step();
      chk("idle_dout", {28'd0, dout},        32'hF);
      chk("idle_pulse", {28'd0, rise | fall}, 32'h0);
      chk("idle_chg",  {28'd0, changed},     32'h0);
      if (c == 1) chk("d1_dout0", {30'd0, dout1}, 32'h1);
      if (c == 2) din1 = 2'b10;
      if (c == 3) begin
        chk("d1_dout", {30'd0, dout1}, 32'h2);
        chk("d1_rise", {30'd0, rise1}, 32'h2);
        chk("d1_fall", {30'd0, fall1}, 32'h1);
      end
      if (c == 4) begin
        chk("d1_pulse_end", {30'd0, rise1 | fall1}, 32'h0);
        chk("d1_chg",       {30'd0, changed1},      32'h3);
      end
    end
    step();

    for (int i = 0; i < 8; i++) apply(i);

    // Bounce din[2] every 3 cycles: no run of mismatch covers more than one tick edge.
    r0 = rise_cnt[2];
    f0 = fall_cnt[2];
    for (int k = 0; k < 10; k++) begin
      din = (k % 2 == 0) ? 4'h8 : 4'hC;
      repeat (3) step();
    end
    chk("bounce_hold", {28'd0, dout}, 32'hC);
    din = 4'h8;
    repeat (8) step();
    chk("bounce_pre",  {28'd0, dout}, 32'hC);
    step();
    chk("bounce_dout", {28'd0, dout},    32'h8);
    chk("bounce_fall", {28'd0, fall},    32'h4);
    chk("bounce_chg",  {28'd0, changed}, 32'h7);
    step();
    chk("bounce_nfall", fall_cnt[2] - f0, 32'd1);
    chk("bounce_nrise", rise_cnt[2] - r0, 32'd0);

    for (int i = 8; i < nv; i++) apply(i);

    // Reset in the middle of qualification.
    din = 4'h0;
    repeat (6) step();
    chk("pre_rst_dout", {28'd0, dout}, 32'h9);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_dout",  {28'd0, dout},        32'hF);
    chk("mid_rst_chg",   {28'd0, changed},     32'h0);
    chk("mid_rst_pulse", {28'd0, rise | fall}, 32'h0);
    chk("mid_rst_tick",  {31'd0, tick},        32'h0);
    step();
    aresetn = 1'b1;
    for (int r = 1; r <= 12; r++) begin
      step();
      chk("post_rst_dout",  {28'd0, dout},        32'hF);
      chk("post_rst_pulse", {28'd0, rise | fall}, 32'h0);
    end
    step();
    chk("post_rst_dout_q", {28'd0, dout},    32'h0);
    chk("post_rst_fall",   {28'd0, fall},    32'hF);
    chk("post_rst_chg",    {28'd0, changed}, 32'hF);
    step();
    chk("post_rst_fall_end", {28'd0, fall}, 32'h0);

    repeat (2) step();
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
